// File: rtl/network_pkg.sv
// network_pkg: shared packet geometry, drop cause codes, rx FSM encoding and checksum helper.
package network_pkg;
  localparam int PAYLOAD_LEN = 4;
  localparam int TCPH_LEN = 20;
  localparam int IPH_LEN = 20;
  localparam int PROTOCOL = 6;
  localparam int PKT_BYTES = PAYLOAD_LEN + IPH_LEN + TCPH_LEN;
  localparam logic [2:0] DROP_NONE = 3'd0;
  localparam logic [2:0] DROP_SHORT = 3'd1;
  localparam logic [2:0] DROP_LONG = 3'd2;
  localparam logic [2:0] DROP_HDR = 3'd3;
  localparam logic [2:0] DROP_LEN = 3'd4;
  localparam logic [2:0] DROP_PROTO = 3'd5;
  localparam logic [2:0] DROP_CSUM = 3'd6;
  typedef enum logic [2:0] {IDLE, RECV, DRAIN, CHECK, HOLD} state_t;
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction
endpackage

// File: rtl/ip_csum_acc.sv
// ip_csum_acc: pairs header bytes into big-endian words and keeps a folded one's-complement sum.
module ip_csum_acc
  import network_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        odd,
  input  logic [7:0]  byte_in,
  output logic [15:0] sum
);
  logic [7:0] hi;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      sum <= '0;
    end else begin
      if (en && !odd) hi <= byte_in;
      sum <= clr ? '0 : (en && odd) ? csum_add(sum, {hi, byte_in}) : sum;
    end
  end
endmodule

// File: rtl/ip_rx_packer.sv
// ip_rx_packer: packs a MAC byte stream into one IPv4+TCP+payload word, validates and drops bad frames.
// Optional header checksum enforcement under IPRX_CSUM_CHECK_EN.
module ip_rx_packer #(
  parameter int PAYLOAD_LEN = network_pkg::PAYLOAD_LEN,
  parameter int TCPH_LEN = network_pkg::TCPH_LEN,
  parameter int IPH_LEN = network_pkg::IPH_LEN,
  parameter int PROTOCOL = network_pkg::PROTOCOL,
  localparam int PKT_BYTES = PAYLOAD_LEN + IPH_LEN + TCPH_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_byte,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [PKT_BYTES*8-1:0] pkt_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic                   drop_pulse,
  output logic [2:0]             drop_cause,
  output logic [15:0]            drop_cnt
);
  import network_pkg::*;
  localparam int IW = $clog2(PKT_BYTES);
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic take, store, last_idx, csum_ok, hdr_ok, len_ok, proto_ok;
  logic [2:0] cause, chk_cause;
  assign take = s_valid && s_ready;
  assign store = take && (state == IDLE || state == RECV);
  assign last_idx = idx == IW'(PKT_BYTES - 1);
  assign hdr_ok = pkt_data[PKT_BYTES*8-1 -: 8] == {4'h4, 4'(IPH_LEN / 4)};
  assign len_ok = pkt_data[PKT_BYTES*8-17 -: 16] == 16'(PKT_BYTES);
  assign proto_ok = pkt_data[(PKT_BYTES-9)*8-1 -: 8] == 8'(PROTOCOL);
  assign chk_cause = !hdr_ok ? DROP_HDR : !len_ok ? DROP_LEN : !proto_ok ? DROP_PROTO :
                     !csum_ok ? DROP_CSUM : DROP_NONE;
`ifdef IPRX_CSUM_CHECK_EN
  logic [15:0] csum;
  ip_csum_acc u_csum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == IDLE),
    .en      (store && idx < IW'(IPH_LEN)),
    .odd     (idx[0]),
    .byte_in (s_byte),
    .sum     (csum)
  );
  assign csum_ok = csum == 16'hFFFF;
`else
  assign csum_ok = 1'b1;
`endif
  always_comb begin
    state_nxt = state;
    cause = DROP_NONE;
    case (state)
      IDLE: if (take && s_last) cause = DROP_SHORT;
            else if (take) state_nxt = RECV;
      RECV: if (take && last_idx) state_nxt = s_last ? CHECK : DRAIN;
            else if (take && s_last) begin
              state_nxt = IDLE;
              cause = DROP_SHORT;
            end
      DRAIN: if (take && s_last) begin
               state_nxt = IDLE;
               cause = DROP_LONG;
             end
      CHECK: begin
        cause = chk_cause;
        state_nxt = chk_cause == DROP_NONE ? HOLD : IDLE;
      end
      HOLD: if (pkt_valid && pkt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // pkt_valid trails HOLD entry by one cycle and drops on the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      s_ready <= 1'b0;
      pkt_data <= '0;
      pkt_valid <= 1'b0;
      drop_pulse <= 1'b0;
      drop_cause <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx <= (state_nxt == RECV) ? (take ? idx + 1'b1 : idx) : '0;
      s_ready <= state_nxt == IDLE || state_nxt == RECV || state_nxt == DRAIN;
      if (store) pkt_data[(PKT_BYTES-int'(idx))*8-1 -: 8] <= s_byte;
      pkt_valid <= pkt_valid ? !pkt_ready : state == HOLD;
      drop_pulse <= cause != DROP_NONE;
      drop_cause <= cause;
      if (cause != DROP_NONE && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ip_rx_packer.sv
// tb_ip_rx_packer: directed checks of ip_rx_packer framing, drops, handshake and reset.
module tb_ip_rx_packer;
  logic clk = 0, rst_n = 0;
  logic [7:0] s_byte = 0;
  logic s_valid = 0, s_last = 0, s_ready;
  logic [351:0] pkt_data;
  logic pkt_valid, pkt_ready = 0, drop_pulse;
  logic [2:0] drop_cause;
  logic [15:0] drop_cnt;
  int total = 0, bad = 0, stalls = 0, c, exp_cnt = 0;
  logic [7:0] fr [64];
  logic [351:0] exp_a, exp_b;

  ip_rx_packer dut (
    .clk(clk), .rst_n(rst_n), .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .drop_pulse(drop_pulse), .drop_cause(drop_cause), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic l);
    int n = 0;
    s_byte = b; s_valid = 1; s_last = l;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (n >= 100) chk("push_timeout", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) push(fr[i], i == n - 1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!pkt_valid && cyc < 100) begin
      step();
      cyc++;
    end
    if (!pkt_valid) chk("valid_timeout", pkt_valid, 1);
  endtask

  function automatic logic [351:0] pack();
    logic [351:0] v;
    for (int i = 0; i < 44; i++) v[(44-i)*8-1 -: 8] = fr[i];
    return v;
  endfunction

  task automatic make_good();
    logic [159:0] h;
    h = 160'h4500002C000140004006B977C0A80001C0A80002;
    for (int i = 0; i < 20; i++) fr[i] = h[159-8*i -: 8];
    for (int i = 20; i < 40; i++) fr[i] = 8'(i * 7);
    for (int i = 40; i < 44; i++) fr[i] = 8'(8'hA0 + i - 40);
  endtask

  initial begin
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_pkt_data", pkt_data, 0);
    chk("rst_drop_pulse", drop_pulse, 0);
    chk("rst_drop_cause", drop_cause, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_s_ready_low", s_ready, 0);
    step();
    chk("rel_s_ready_high", s_ready, 1);

    make_good();
    exp_a = pack();
    pkt_ready = 1;
    send(44);
    chk("t1_pv_e0", pkt_valid, 0);
    step();
    chk("t1_pv_e1", pkt_valid, 0);
    chk("t1_s_ready_check", s_ready, 0);
    step();
    chk("t1_pv_e2", pkt_valid, 1);
    chk("t1_data", pkt_data, exp_a);
    chk("t1_byte0", pkt_data[351:344], 8'h45);
    chk("t1_len", pkt_data[335:320], 16'h002C);
    step();
    chk("t1_pv_after_hs", pkt_valid, 0);
    chk("t1_s_ready_after_hs", s_ready, 1);
    chk("t1_drop_cnt", drop_cnt, 0);

    pkt_ready = 0;
    send(44);
    wait_valid(c);
    chk("t2_latency", c, 2);
    s_byte = 8'h45; s_valid = 1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_pv", pkt_valid, 1);
      chk("t2_hold_s_ready", s_ready, 0);
      chk("t2_hold_data", pkt_data, exp_a);
      step();
    end
    fr[40] = 8'hDE; fr[41] = 8'hAD; fr[42] = 8'hBE; fr[43] = 8'hEF;
    exp_b = pack();
    pkt_ready = 1;
    send(44);
    wait_valid(c);
    chk("t2_b_data", pkt_data, exp_b);
    step();
    chk("t2_b_pv_low", pkt_valid, 0);
    make_good();

    send(31);
    exp_cnt++;
    chk("t3_pulse", drop_pulse, 1);
    chk("t3_cause", drop_cause, 3'd1);
    chk("t3_cnt", drop_cnt, exp_cnt);
    step();
    chk("t3_pulse_end", drop_pulse, 0);
    chk("t3_pv", pkt_valid, 0);

    for (int i = 44; i < 50; i++) fr[i] = 8'(i);
    stalls = 0;
    send(50);
    exp_cnt++;
    chk("t4_no_stall", stalls, 0);
    chk("t4_pulse", drop_pulse, 1);
    chk("t4_cause", drop_cause, 3'd2);
    chk("t4_cnt", drop_cnt, exp_cnt);
    step();
    step();
    chk("t4_pv", pkt_valid, 0);

    fr[9] = 8'h11;
    send(44);
    step();
    exp_cnt++;
    chk("t5_proto_pulse", drop_pulse, 1);
    chk("t5_proto_cause", drop_cause, 3'd5);
    chk("t5_proto_cnt", drop_cnt, exp_cnt);
    fr[9] = 8'h06;
    fr[0] = 8'h46;
    send(44);
    step();
    exp_cnt++;
    chk("t5_hdr_cause", drop_cause, 3'd3);
    chk("t5_hdr_cnt", drop_cnt, exp_cnt);
    fr[0] = 8'h45;
    fr[3] = 8'h2D;
    send(44);
    step();
    exp_cnt++;
    chk("t5_len_cause", drop_cause, 3'd4);
    chk("t5_len_cnt", drop_cnt, exp_cnt);
    fr[3] = 8'h2C;
    fr[12] = 8'hC1;
    send(44);
    step();
`ifdef IPRX_CSUM_CHECK_EN
    exp_cnt++;
    chk("t5_csum_pulse", drop_pulse, 1);
    chk("t5_csum_cause", drop_cause, 3'd6);
    chk("t5_csum_cnt", drop_cnt, exp_cnt);
    step();
    chk("t5_csum_pv", pkt_valid, 0);
`else
    chk("t5_csum_no_drop", drop_pulse, 0);
    step();
    chk("t5_csum_pv", pkt_valid, 1);
    chk("t5_csum_data", pkt_data, pack());
    step();
    chk("t5_csum_cnt", drop_cnt, exp_cnt);
`endif
    fr[12] = 8'hC0;

    for (int i = 0; i < 20; i++) push(fr[i], 0);
    rst_n = 0;
    #1;
    chk("t6_s_ready", s_ready, 0);
    chk("t6_pv", pkt_valid, 0);
    chk("t6_data", pkt_data, 0);
    chk("t6_pulse", drop_pulse, 0);
    chk("t6_cause", drop_cause, 0);
    chk("t6_cnt", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    step();
    fr[40] = 8'h11; fr[41] = 8'h22; fr[42] = 8'h33; fr[43] = 8'h44;
    send(44);
    wait_valid(c);
    chk("t6_after_latency", c, 2);
    chk("t6_after_data", pkt_data, pack());
    chk("t6_after_cnt", drop_cnt, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
